clut_writer: RTL and testbench
==============================

Name: clut_writer

Overview:
- CPU-facing writer for the pixel pipeline. It loads colour lookup table entries into clut_mem through its write port (we/addr_write/data_in), and loads sprite position registers (sprx/spry).
- All visible updates happen only during vertical blanking or at the frame pulse, so the display never tears mid-frame.
- Sits between the CPU bus and the VGA bit generator, clocked in the 25 MHz pixel domain.

Parameters:
- CORDW, 16, signed sprite coordinate width (bits)
- COLRW, 12, colour entry width (3 x 4-bit channels)
- CIDXW, 4, CLUT index width (16 entries)
- FIFO_DEPTH, 8, pending CLUT-write buffer depth (power of 2)
- RST_SPRX, 288, sprx value after reset (H_RES/2 - SPR_DRAWW/2)
- RST_SPRY, 208, spry value after reset (V_RES/2 - SPR_DRAWH/2)

Ports:
- clk  in  1  pixel clock (clk_25MHz)
- rst  in  1  synchronous active-high reset
- cpu_valid  in  1  write request valid
- cpu_ready  out  1  writer can accept a request this cycle
- cpu_addr  in  5  register address (map below)
- cpu_data  in  16  write data
- vblank  in  1  high while the vertical count is at or beyond V_RES
- frame  in  1  one-cycle pulse at the start of a frame
- mem_we  out  1  CLUT write enable
- mem_addr  out  CIDXW  CLUT write index
- mem_data  out  COLRW  CLUT write colour
- sprx  out  CORDW  live sprite x (signed)
- spry  out  CORDW  live sprite y (signed)
- err  out  1  sticky bad-address flag

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk is the clock, and rst is sampled only on the rising edge of clk.
- Reset values:
  - cpu_ready=0 during the reset cycle, 1 afterwards.
  - mem_we=0, mem_addr=0, mem_data=0.
  - sprx=RST_SPRX, spry=RST_SPRY; shadow_x=RST_SPRX, shadow_y=RST_SPRY.
  - err=0; FIFO emptied.
- Address map (cpu_addr):
  - 0x00-0x0F: CLUT entry; index = cpu_addr[3:0], colour = cpu_data[11:0], cpu_data[15:12] ignored.
  - 0x10: shadow_x <= cpu_data (signed, full width).
  - 0x11: shadow_y <= cpu_data.
  - 0x12-0x1F: request accepted, data discarded, err <= 1 (sticky until rst).
- Handshake:
  - A request transfers on a clock edge where cpu_valid && cpu_ready.
  - cpu_ready = !fifo_full && !rst.
  - Shadow-register and bad-address writes complete in the accept cycle. They never stall, but they still obey cpu_ready.
- CLUT path:
  - An accepted CLUT write pushes {index, colour} into the FIFO.
  - Pop condition: vblank && !fifo_empty; at most one pop per cycle.
  - mem_we/mem_addr/mem_data are registered. A pop at cycle t gives mem_we=1 with the popped entry at t+1; otherwise mem_we=0 at t+1. mem_addr/mem_data hold their last values while mem_we=0.
  - Latency: a CLUT write accepted at t with the FIFO empty and vblank high through t+1 gives mem_we=1 at t+2.
  - Order is preserved; repeated writes to the same index are all issued, so the last write wins.
  - Push and pop in the same cycle are legal: occupancy is unchanged.
  - Full: cpu_ready=0 and the CPU must stall, so no request is ever dropped.
  - vblank falling with entries pending: draining stops, entries are kept, and draining resumes in the next blanking interval.
- Position path:
  - On frame=1: sprx<=shadow_x, spry<=shadow_y.
  - If a shadow write is accepted on the same edge as frame, the live registers take the OLD shadow value; the new value applies at the next frame pulse.
  - With no shadow writes, sprx/spry are stable across frames.
- Reset mid-operation: the FIFO is flushed (pending CLUT writes are lost), any mem_we due next cycle is suppressed, and position and err are reinitialised.
- Arithmetic: FIFO pointers are log2(FIFO_DEPTH)+1 bits with an MSB wrap bit. Full when the low bits are equal and the MSBs differ; empty when the pointers are equal.

Decomposition:
- Shared package/header: the address-map constants (CLUT_BASE=0x00, REG_SPRX=0x10, REG_SPRY=0x11), the CHANW/COLRW/CIDXW colour widths, CORDW, and the H_RES/V_RES screen dimensions. These are shared with the bit generator and sprite blocks.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty). The rest (decode, shadow registers, output register) stays in clut_writer.

Test Plan:
- Reset, then write 0x05 <- 0x0F80 with vblank=1 -> mem_we=1, mem_addr=5, mem_data=0xF80 exactly two cycles after accept; afterwards mem_we=0.
- vblank=0 and 9 back-to-back CLUT writes -> 8 accepted, cpu_ready=0 on the 9th and mem_we stays 0. Raise vblank -> 8 pulses in order, cpu_ready returns to 1, then the 9th entry is issued.
- vblank high for 3 cycles with 6 entries queued -> exactly 3 writes. Next vblank -> remaining 3 in order, none lost or duplicated.
- Write 0x10 <- 0xFFC0 (-64), then pulse frame -> sprx=-64 only after the frame edge; spry unchanged at 208.
- Shadow write 0x11 <- 100 on the same cycle as frame -> spry stays at its previous value; next frame -> spry=100.
- Write to 0x15 -> err=1 and no mem_we. Assert rst with 4 entries queued -> err=0, sprx=288, spry=208, and no mem_we in the following vblank.

Source files
------------

// File: rtl/clut_writer_pkg.sv
// rtl/clut_writer_pkg.sv - shared widths, screen geometry and register map for the pixel pipeline
package clut_writer_pkg;

  localparam int CHANW     = 4;
  localparam int COLRW     = 3 * CHANW;
  localparam int CIDXW     = 4;
  localparam int CORDW     = 16;
  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int SPR_DRAWW = 64;
  localparam int SPR_DRAWH = 64;
  localparam int ADDRW     = 5;
  localparam int DATAW     = 16;

  localparam logic [ADDRW-1:0] CLUT_BASE = 5'h00;
  localparam logic [ADDRW-1:0] REG_SPRX  = 5'h10;
  localparam logic [ADDRW-1:0] REG_SPRY  = 5'h11;

  typedef enum logic [1:0] {
    DEC_CLUT,
    DEC_SPRX,
    DEC_SPRY,
    DEC_BAD
  } dec_e;

  // Upper address bits select the CLUT window; everything above the two sprite regs is invalid.
  function automatic dec_e decode(input logic [ADDRW-1:0] a);
    if (a[ADDRW-1:CIDXW] == CLUT_BASE[ADDRW-1:CIDXW]) return DEC_CLUT;
    else if (a == REG_SPRX) return DEC_SPRX;
    else if (a == REG_SPRY) return DEC_SPRY;
    else return DEC_BAD;
  endfunction

endpackage

// File: rtl/clut_writer_sync_fifo.sv
// rtl/clut_writer_sync_fifo.sv - single-clock FIFO holding CLUT writes until blanking
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the index bits match.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/clut_writer.sv
// rtl/clut_writer.sv - CPU writer for CLUT entries and sprite position, updating only in blanking
module clut_writer
  import clut_writer_pkg::*;
#(
  parameter int CORDW      = clut_writer_pkg::CORDW,
  parameter int COLRW      = clut_writer_pkg::COLRW,
  parameter int CIDXW      = clut_writer_pkg::CIDXW,
  parameter int FIFO_DEPTH = 8,
  parameter int RST_SPRX   = 288,
  parameter int RST_SPRY   = 208
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_valid,
  output logic                    cpu_ready,
  input  logic [4:0]              cpu_addr,
  input  logic [15:0]             cpu_data,
  input  logic                    vblank,
  input  logic                    frame,
  output logic                    mem_we,
  output logic [CIDXW-1:0]        mem_addr,
  output logic [COLRW-1:0]        mem_data,
  output logic signed [CORDW-1:0] sprx,
  output logic signed [CORDW-1:0] spry,
  output logic                    err
);

  localparam int ENTW = CIDXW + COLRW;

  dec_e            dec;
  logic            accept, push, pop;
  logic            fifo_full, fifo_empty;
  logic [ENTW-1:0] pop_entry;

  logic                    mem_we_q, mem_we_d;
  logic [CIDXW-1:0]        mem_addr_q, mem_addr_d;
  logic [COLRW-1:0]        mem_data_q, mem_data_d;
  logic signed [CORDW-1:0] shadow_x_q, shadow_x_d;
  logic signed [CORDW-1:0] shadow_y_q, shadow_y_d;
  logic signed [CORDW-1:0] sprx_q, sprx_d;
  logic signed [CORDW-1:0] spry_q, spry_d;
  logic                    err_q, err_d;

  assign cpu_ready = !fifo_full && !rst;
  assign accept    = cpu_valid && cpu_ready;
  assign dec       = decode(cpu_addr);
  assign push      = accept && (dec == DEC_CLUT);
  assign pop       = vblank && !fifo_empty;

  sync_fifo #(
    .WIDTH (ENTW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({cpu_addr[CIDXW-1:0], cpu_data[COLRW-1:0]}),
    .pop       (pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    mem_we_d   = pop;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    shadow_x_d = shadow_x_q;
    shadow_y_d = shadow_y_q;
    sprx_d     = sprx_q;
    spry_d     = spry_q;
    err_d      = err_q;

    if (pop) begin
      mem_addr_d = pop_entry[ENTW-1:COLRW];
      mem_data_d = pop_entry[COLRW-1:0];
    end

    if (accept) begin
      case (dec)
        DEC_SPRX: shadow_x_d = CORDW'($signed(cpu_data));
        DEC_SPRY: shadow_y_d = CORDW'($signed(cpu_data));
        DEC_BAD:  err_d      = 1'b1;
        default:  ;
      endcase
    end

    // Live position samples the shadow as it stood before this edge's CPU write.
    if (frame) begin
      sprx_d = shadow_x_q;
      spry_d = shadow_y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      shadow_x_q <= CORDW'(RST_SPRX);
      shadow_y_q <= CORDW'(RST_SPRY);
      sprx_q     <= CORDW'(RST_SPRX);
      spry_q     <= CORDW'(RST_SPRY);
      err_q      <= 1'b0;
    end else begin
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      shadow_x_q <= shadow_x_d;
      shadow_y_q <= shadow_y_d;
      sprx_q     <= sprx_d;
      spry_q     <= spry_d;
      err_q      <= err_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign sprx     = sprx_q;
  assign spry     = spry_q;
  assign err      = err_q;

endmodule

// File: tb/tb_clut_writer.sv
// tb/tb_clut_writer.sv - scoreboard bench for clut_writer with a queue-based reference model
module tb_clut_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_valid = 1'b0;
  logic [4:0]  cpu_addr = '0;
  logic [15:0] cpu_data = '0;
  logic        vblank = 1'b0;
  logic        frame = 1'b0;
  logic        cpu_ready, mem_we, err;
  logic [3:0]  mem_addr;
  logic [11:0] mem_data;
  logic signed [15:0] sprx, spry;

  clut_writer dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_valid (cpu_valid),
    .cpu_ready (cpu_ready),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .vblank    (vblank),
    .frame     (frame),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .sprx      (sprx),
    .spry      (spry),
    .err       (err)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending CLUT writes, issued writes awaiting the monitor, and register state.
  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  bit          m_we, m_acc, m_err, acc;
  logic [3:0]  m_addr;
  logic [11:0] m_data;
  logic [15:0] m_sx, m_sy, m_px, m_py, me, pe;
  int          we_cnt = 0;

  always @(posedge clk) begin
    m_acc = 1'b0;
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0;
      m_sx = 16'd288; m_sy = 16'd208; m_px = 16'd288; m_py = 16'd208;
      m_err = 1'b0;
    end else begin
      acc = cpu_valid && (mq.size() < 8);
      if (frame) begin
        m_px = m_sx;
        m_py = m_sy;
      end
      m_we = 1'b0;
      if (vblank && mq.size() > 0) begin
        pe = mq.pop_front();
        exp_q.push_back(pe);
        m_we = 1'b1; m_addr = pe[15:12]; m_data = pe[11:0];
      end
      if (acc) begin
        m_acc = 1'b1;
        if (cpu_addr < 5'h10)       mq.push_back({cpu_addr[3:0], cpu_data[11:0]});
        else if (cpu_addr == 5'h10) m_sx = cpu_data;
        else if (cpu_addr == 5'h11) m_sy = cpu_data;
        else                        m_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cpu_ready", {15'd0, cpu_ready}, {15'd0, (!rst && mq.size() < 8)});
    chk("mem_we", {15'd0, mem_we}, {15'd0, m_we});
    if (mem_we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL mem_entry: got unexpected write 0x%0h expected none", {mem_addr, mem_data});
      end else begin
        me = exp_q.pop_front();
        chk("mem_entry", {mem_addr, mem_data}, me);
      end
    end else begin
      chk("mem_hold", {mem_addr, mem_data}, {m_addr, m_data});
    end
    chk("sprx", sprx, m_px);
    chk("spry", spry, m_py);
    chk("err", {15'd0, err}, {15'd0, m_err});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    int k;
    cpu_valid = 1'b1; cpu_addr = a; cpu_data = d;
    k = 0;
    do begin
      tick();
      k++;
    end while (!m_acc && k < 200);
    if (!m_acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no accept for addr 0x%0h expected accept", a);
    end
    cpu_valid = 1'b0;
  endtask

  int w0;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // single CLUT write, two-cycle latency
    vblank = 1'b1;
    wr(5'h05, 16'h0F80);
    @(negedge clk); chk("t1_lat_early", {15'd0, mem_we}, 16'd0);
    @(negedge clk); chk("t1_we", {15'd0, mem_we}, 16'd1);
    chk("t1_addr", {12'd0, mem_addr}, 16'd5);
    chk("t1_data", {4'd0, mem_data}, 16'h0F80);
    @(negedge clk); chk("t1_we_off", {15'd0, mem_we}, 16'd0);

    // fill FIFO outside blanking, ninth write stalls
    vblank = 1'b0;
    tick();
    w0 = we_cnt;
    for (int i = 0; i < 8; i++) wr(5'(i), 16'($urandom));
    cpu_valid = 1'b1; cpu_addr = 5'h08; cpu_data = 16'h0ABC;
    repeat (3) tick();
    @(negedge clk);
    chk("t2_stall", {15'd0, cpu_ready}, 16'd0);
    chk("t2_no_we", 16'(we_cnt - w0), 16'd0);
    vblank = 1'b1;
    wr(5'h08, 16'h0ABC);
    repeat (12) tick();
    @(negedge clk);
    chk("t2_drained", 16'(we_cnt - w0), 16'd9);
    chk("t2_ready", {15'd0, cpu_ready}, 16'd1);

    // partial drain across two blanking intervals
    vblank = 1'b0;
    tick();
    w0 = we_cnt;
    for (int i = 0; i < 6; i++) wr(5'($urandom_range(0, 15)), 16'($urandom));
    vblank = 1'b1;
    repeat (3) tick();
    vblank = 1'b0;
    repeat (4) tick();
    chk("t3_partial", 16'(we_cnt - w0), 16'd3);
    vblank = 1'b1;
    repeat (8) tick();
    chk("t3_rest", 16'(we_cnt - w0), 16'd6);
    vblank = 1'b0;

    // sprite x applies only at frame
    wr(5'h10, 16'hFFC0);
    @(negedge clk); chk("t4_before", sprx, 16'd288);
    frame = 1'b1; tick(); frame = 1'b0;
    @(negedge clk);
    chk("t4_sprx", sprx, 16'hFFC0);
    chk("t4_spry", spry, 16'd208);

    // shadow write coinciding with frame
    frame = 1'b1; cpu_valid = 1'b1; cpu_addr = 5'h11; cpu_data = 16'd100;
    tick();
    frame = 1'b0; cpu_valid = 1'b0;
    @(negedge clk); chk("t5_old", spry, 16'd208);
    frame = 1'b1; tick(); frame = 1'b0;
    @(negedge clk); chk("t5_new", spry, 16'd100);

    // bad address, then reset with pending entries
    w0 = we_cnt;
    wr(5'h15, 16'h1234);
    @(negedge clk); chk("t6_err", {15'd0, err}, 16'd1);
    for (int i = 0; i < 4; i++) wr(5'(i + 3), 16'($urandom));
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("t6_err_clr", {15'd0, err}, 16'd0);
    chk("t6_sprx", sprx, 16'd288);
    chk("t6_spry", spry, 16'd208);
    vblank = 1'b1;
    repeat (10) tick();
    chk("t6_flushed", 16'(we_cnt - w0), 16'd0);

    // randomized traffic
    repeat (500) begin
      cpu_valid = 1'($urandom_range(0, 1));
      cpu_addr  = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(16, 31));
      cpu_data  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) vblank = ~vblank;
      frame = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    cpu_valid = 1'b0; rst = 1'b0; frame = 1'b0; vblank = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    chk("final_idle_ready", {15'd0, cpu_ready}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
